// File: rtl/lift_disp_pkg.sv
// Shared constants and helpers for the lift floor display.
// Latency: none (package of constants and a combinational helper).
// Backpressure: not applicable.
//
// Holds the seven-segment patterns (a = bit 6, active-high), the direction
// codes seen on the lift controller's direction bus, and a BCD-to-segment
// lookup used by the display scanner.
package lift_disp_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1111110, // 0
        7'b0110000, // 1
        7'b1101101, // 2
        7'b1111001, // 3
        7'b0110011, // 4
        7'b1011011, // 5
        7'b1011111, // 6
        7'b1110000, // 7
        7'b1111111, // 8
        7'b1111011  // 9
    };
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_BAD  = 2'b11
    } dir_e;

    // Non-decimal codes never come out of the converter; blank them anyway.
    function automatic logic [6:0] seg_of_bcd(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/lift_floor_display_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter.
// Latency: start in cycle 0, done pulses in cycle IN_W with bcd valid.
// Backpressure: none; a start during a conversion restarts it.
//
// Ports: clk, rst_n (sync, active-low), start (1-cycle), bin (IN_W),
//        done (1-cycle), bcd (4*DIGITS, digit 0 in bits [3:0]).
module lift_bin2bcd_seq #(
    parameter int IN_W   = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    import lift_disp_pkg::*;

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    logic [BCD_W-1:0] bcd_r;
    logic [IN_W-1:0]  sh_r;
    logic [CNT_W-1:0] cnt_r;

    // One iteration: add 3 to every BCD digit >= 5, then shift the whole
    // {bcd, binary} register left by one.
    function automatic logic [BCD_W+IN_W-1:0] dd_step(
        input logic [BCD_W-1:0] b,
        input logic [IN_W-1:0]  s
    );
        logic [BCD_W-1:0] adj;
        adj = b;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        return {adj, s} << 1;
    endfunction

    // The first iteration happens on the start edge itself, so IN_W
    // iterations complete IN_W cycles after start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_r <= '0;
            sh_r  <= '0;
            cnt_r <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {bcd_r, sh_r} <= dd_step('0, bin);
                cnt_r         <= CNT_W'(IN_W - 1);
                done          <= (IN_W == 1);
            end else if (cnt_r != '0) begin
                {bcd_r, sh_r} <= dd_step(bcd_r, sh_r);
                cnt_r         <= cnt_r - CNT_W'(1);
                done          <= (cnt_r == CNT_W'(1));
            end
        end
    end

    assign bcd = bcd_r;

endmodule

// File: rtl/lift_floor_display.sv
// Scanned seven-segment floor display with range check and direction arrow.
// Latency: floor_valid to new digits FLOOR_W+1 cycles; out-of-range dash 1 cycle.
// Backpressure: none; strobes during busy land in a one-deep overwrite register.
//
// Ports: clk, rst_n (sync, active-low), floor_bin/floor_valid (floor strobe),
//        direction (00 idle, 01 up, 10 down, 11 bad), door_open,
//        seg_a_to_g (a = bit 6), digit_en (one-hot, bit 0 = LSD), arrow
//        (bit 0 up, bit 1 down), busy, err. All outputs registered.
// Build option: define LIFT_DISP_BLINK_EN to blink the arrow while moving.
module lift_floor_display #(
    parameter  int NUM_FLOORS = 16,
    parameter  int NUM_DIGITS = 2,
    parameter  int SCAN_DIV   = 1000,
    parameter  int BLINK_DIV  = 250000,
    localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLOOR_W-1:0]    floor_bin,
    input  logic                  floor_valid,
    input  logic [1:0]            direction,
    input  logic                  door_open,
    output logic [6:0]            seg_a_to_g,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [1:0]            arrow,
    output logic                  busy,
    output logic                  err
);
    import lift_disp_pkg::*;

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

    // ---------------- capture / pending ----------------
    logic [FLOOR_W-1:0] pend_val;
    logic               pend_vld;
    logic [FLOOR_W-1:0] cap_val;
    logic               cap_vld, cap_bad, conv_start, pend_load;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic [BCD_W-1:0]   shown, shown_nxt;
    logic               err_nxt;

    // A waiting pending value takes priority over a fresh strobe; a strobe
    // arriving in that same cycle simply refills the pending slot.
    assign cap_vld    = !busy && (pend_vld || floor_valid);
    assign cap_val    = pend_vld ? pend_val : floor_bin;
    assign cap_bad    = ({1'b0, cap_val} >= FLOOR_LIMIT);
    assign conv_start = cap_vld && !cap_bad;
    assign pend_load  = floor_valid && (busy || pend_vld);
    assign err_nxt    = cap_vld ? cap_bad : err;
    assign shown_nxt  = conv_done ? conv_bcd : shown;

    lift_bin2bcd_seq #(
        .IN_W   (FLOOR_W),
        .DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (cap_val),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // ---------------- scan ----------------
    logic [SCAN_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic                  scan_wrap;
    logic [NUM_DIGITS-1:0] digit_en_nxt;
    logic [6:0]            seg_nxt;
    logic [3:0]            cur_dig;
    logic                  cur_blank, higher_zero;

    assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        idx_nxt = idx;
        if (scan_wrap)
            idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end

    // Segments are computed from next-state values so that the registered
    // seg_a_to_g always matches the registered digit_en.
    always_comb begin
        digit_en_nxt = '0;
        cur_dig      = 4'd0;
        cur_blank    = 1'b0;
        higher_zero  = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            higher_zero = higher_zero && (shown_nxt[4*j +: 4] == 4'd0);
            if (IDX_W'(j) == idx_nxt) begin
                digit_en_nxt[j] = 1'b1;
                cur_dig         = shown_nxt[4*j +: 4];
                cur_blank       = higher_zero && (j != 0);
            end
        end
        if (err_nxt)
            seg_nxt = SEG_DASH;
        else if (cur_blank)
            seg_nxt = SEG_BLANK;
        else
            seg_nxt = seg_of_bcd(cur_dig);
    end

    // ---------------- arrow ----------------
    logic       blink_on;
    logic [1:0] arrow_nxt;

`ifdef LIFT_DISP_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;

    // Free-running; direction changes do not restart the phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= !blink_ph;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end
    assign blink_on = blink_ph;
`else
    assign blink_on = 1'b1;
`endif

    always_comb begin
        arrow_nxt = 2'b00;
        if (direction == DIR_UP || direction == DIR_DOWN)
            arrow_nxt = (door_open || blink_on) ? direction : 2'b00;
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_vld   <= 1'b0;
            shown      <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            scan_cnt   <= '0;
            idx        <= '0;
            seg_a_to_g <= SEG_DIGIT[0];
            digit_en   <= NUM_DIGITS'(1);
            arrow      <= 2'b00;
        end else begin
            if (pend_load) begin
                pend_val <= floor_bin;
                pend_vld <= 1'b1;
            end else if (cap_vld) begin
                pend_vld <= 1'b0;
            end
            if (conv_start)
                busy <= 1'b1;
            else if (conv_done)
                busy <= 1'b0;
            err        <= err_nxt;
            shown      <= shown_nxt;
            scan_cnt   <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
            idx        <= idx_nxt;
            seg_a_to_g <= seg_nxt;
            digit_en   <= digit_en_nxt;
            arrow      <= arrow_nxt;
        end
    end

endmodule

// File: tb/tb_lift_floor_display.sv
module tb_lift_floor_display;

    localparam int NF = 13;
    localparam int ND = 2;
    localparam int SD = 4;
    localparam int BD = 3;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [FW-1:0] floor_bin;
    logic          floor_valid;
    logic [1:0]    direction;
    logic          door_open;
    logic [6:0]    seg_a_to_g;
    logic [ND-1:0] digit_en;
    logic [1:0]    arrow;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];   // expected shown value; -1 means dashes

    lift_floor_display #(
        .NUM_FLOORS (NF),
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .floor_bin   (floor_bin),
        .floor_valid (floor_valid),
        .direction   (direction),
        .door_open   (door_open),
        .seg_a_to_g  (seg_a_to_g),
        .digit_en    (digit_en),
        .arrow       (arrow),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int dig);
        if (v < 0) return 7'b0000001;
        if (dig == 0) return pat(v % 10);
        return ((v / 10) == 0) ? 7'b0000000 : pat(v / 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int v);
        floor_bin   = v[FW-1:0];
        floor_valid = 1'b1;
        tick();
        floor_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Checks only the digit enabled right now.
    task automatic check_current(input string tag, input int v);
        int d;
        d = (digit_en == 2'b10) ? 1 : 0;
        chk({tag, "_onehot"}, 32'((digit_en == 2'b01) || (digit_en == 2'b10)), 32'd1);
        chk({tag, "_seg"}, 32'(seg_a_to_g), 32'(exp_seg(v, d)));
    endtask

    // Visits every digit in turn and checks its pattern.
    task automatic check_display(input string tag, input int v);
        for (int d = 0; d < ND; d++) begin
            int n = 0;
            while (digit_en !== ND'(1 << d) && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("%s_d%0d_en", tag, d), 32'(digit_en), 32'(1 << d));
            chk($sformatf("%s_d%0d_seg", tag, d), 32'(seg_a_to_g), 32'(exp_seg(v, d)));
        end
    endtask

    initial begin
        int v, n, len;
        logic [ND-1:0] en0;
        logic [1:0] a0, first, ea;

        rst_n = 1'b0; floor_valid = 1'b0; floor_bin = '0;
        direction = 2'b00; door_open = 1'b0;

        // Reset
        repeat (3) tick();
        chk("rst_seg", 32'(seg_a_to_g), 32'h7e);
        chk("rst_en", 32'(digit_en), 32'd1);
        chk("rst_arrow", 32'(arrow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_seg", 32'(seg_a_to_g), 32'h7e);
        chk("post_rst_en", 32'(digit_en), 32'd1);

        // Two-digit floor with exact latency
        exp_q.push_back(12);
        strobe(12);
        for (int i = 1; i <= FW; i++) begin
            chk($sformatf("f12_busy_c%0d", i), 32'(busy), 32'd1);
            tick();
        end
        chk("f12_busy_done", 32'(busy), 32'd0);
        v = exp_q.pop_front();
        check_current("f12_first", v);
        check_display("f12", v);

        // Scan period: each digit stays enabled SD cycles
        n = 0;
        en0 = digit_en;
        while (digit_en == en0 && n < 20) begin tick(); n++; end
        en0 = digit_en;
        len = 0;
        while (digit_en == en0 && len < 20) begin tick(); len++; end
        chk("scan_period", 32'(len), 32'(SD));

        // Leading-zero blanking
        exp_q.push_back(7);
        strobe(7);
        wait_idle("f7");
        check_display("f7", exp_q.pop_front());

        // Out of range (first invalid floor), then recovery
        exp_q.push_back(-1);
        strobe(13);
        chk("oor13_err", 32'(err), 32'd1);
        chk("oor13_busy", 32'(busy), 32'd0);
        v = exp_q.pop_front();
        check_current("oor13_first", v);
        check_display("oor13", v);
        exp_q.push_back(3);
        strobe(3);
        chk("f3_err_clr", 32'(err), 32'd0);
        chk("f3_busy", 32'(busy), 32'd1);
        wait_idle("f3");
        check_display("f3", exp_q.pop_front());

        exp_q.push_back(-1);
        strobe(15);
        chk("oor15_err", 32'(err), 32'd1);
        check_display("oor15", exp_q.pop_front());
        exp_q.push_back(0);
        strobe(0);
        wait_idle("f0");
        chk("f0_err", 32'(err), 32'd0);
        check_display("f0", exp_q.pop_front());

        // Back-to-back: 5, then 9 and 8 while busy (8 overwrites 9)
        exp_q.push_back(5);
        strobe(5);
        floor_bin = 4'd9; floor_valid = 1'b1;
        exp_q.push_back(9);
        tick();
        floor_bin = 4'd8;
        void'(exp_q.pop_back());
        exp_q.push_back(8);
        tick();
        floor_valid = 1'b0;
        tick(); tick();
        chk("b2b_c5_busy", 32'(busy), 32'd0);
        check_current("b2b_first", exp_q.pop_front());
        tick();
        for (int c = 6; c <= 2 * FW + 1; c++) begin
            chk($sformatf("b2b_busy_c%0d", c), 32'(busy), 32'd1);
            tick();
        end
        chk("b2b_c10_busy", 32'(busy), 32'd0);
        v = exp_q.pop_front();
        check_current("b2b_second", v);
        check_display("b2b", v);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-conversion with a pending value loaded
        strobe(9);
        floor_bin = 4'd11; floor_valid = 1'b1;
        tick();
        floor_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_seg", 32'(seg_a_to_g), 32'h7e);
        chk("mrst_en", 32'(digit_en), 32'd1);
        repeat (FW + 3) tick();
        chk("mrst_no_pending", 32'(busy), 32'd0);
        check_display("mrst", 0);

        // Arrow
        direction = 2'b01; door_open = 1'b0;
        tick(); tick();
`ifdef LIFT_DISP_BLINK_EN
        a0 = arrow;
        n = 0;
        while (arrow == a0 && n < 10) begin tick(); n++; end
        chk("blink_edge", 32'(arrow != a0), 32'd1);
        first = arrow;
        for (int k = 0; k < 12; k++) begin
            ea = (((k / BD) % 2) == 0) ? first : ((first == 2'b01) ? 2'b00 : 2'b01);
            chk($sformatf("blink_k%0d", k), 32'(arrow), 32'(ea));
            tick();
        end
`else
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("steady_up_k%0d", k), 32'(arrow), 32'd1);
            tick();
        end
`endif
        door_open = 1'b1;
        tick(); tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("door_up_k%0d", k), 32'(arrow), 32'd1);
            tick();
        end
        direction = 2'b10;
        tick(); tick();
        chk("door_down", 32'(arrow), 32'd2);
        door_open = 1'b0; direction = 2'b11;
        tick(); tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bad_dir_k%0d", k), 32'(arrow), 32'd0);
            tick();
        end
        direction = 2'b00;
        tick(); tick();
        chk("idle_dir", 32'(arrow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
